// File: rtl/sram1024x18_arb.sv
// sram1024x18_arb: round-robin two-requester arbiter and power-up initialiser for one sram1024x18 port
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   reqN_valid/ready/we/addr/wdata/wmsk   requester N command handshake (N = 0, 1)
//   rspN_valid/data             requester N read response, fixed 2-edge latency
//   init_busy                   high while the power-up clear is pending or running
//   sram_cen/wen/addr/wmsk/wdata/rdata   registered macro port pins
module sram1024x18_arb #(
    parameter bit          INIT_EN    = 1'b1,
    parameter logic [17:0] INIT_VALUE = 18'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [9:0]  req0_addr,
    input  logic [17:0] req0_wdata,
    input  logic [17:0] req0_wmsk,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [9:0]  req1_addr,
    input  logic [17:0] req1_wdata,
    input  logic [17:0] req1_wmsk,
    output logic        rsp0_valid,
    output logic [17:0] rsp0_data,
    output logic        rsp1_valid,
    output logic [17:0] rsp1_data,
    output logic        init_busy,
    output logic        sram_cen,
    output logic        sram_wen,
    output logic [9:0]  sram_addr,
    output logic [17:0] sram_wmsk,
    output logic [17:0] sram_wdata,
    input  logic [17:0] sram_rdata
);
    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
    state_t      r_state, w_next;
    logic [9:0]  r_cnt;
    logic        r_ptr;
    logic        r_t1_v, r_t1_id, r_t2_v, r_t2_id;
    logic        w_g0, w_g1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE) ? (INIT_EN ? INIT : RUN) :
                 (r_state == INIT && r_cnt == 10'd1023) ? RUN : r_state;
    end
    // Ready ignores the requester's own valid; the pointer only breaks ties.
    always_comb begin
        req0_ready = (r_state == RUN) & (!req1_valid | !r_ptr);
        req1_ready = (r_state == RUN) & (!req0_valid | r_ptr);
        init_busy  = (r_state == INIT) | (r_state == IDLE & INIT_EN);
        w_g0       = req0_valid & req0_ready;
        w_g1       = req1_valid & req1_ready;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ptr <= 1'b0;
        end else begin
            if (r_state == INIT && r_cnt != 10'd1023) r_cnt <= r_cnt + 10'd1;
            if (w_g0 | w_g1) r_ptr <= w_g0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_cen   <= 1'b1;
            sram_wen   <= 1'b1;
            sram_addr  <= '0;
            sram_wmsk  <= '1;
            sram_wdata <= '0;
        end else if (r_state == INIT) begin
            sram_cen   <= 1'b0;
            sram_wen   <= 1'b0;
            sram_addr  <= r_cnt;
            sram_wmsk  <= '0;
            sram_wdata <= INIT_VALUE;
        end else if (w_g0 | w_g1) begin
            sram_cen   <= 1'b0;
            sram_wen   <= w_g1 ? !req1_we : !req0_we;
            sram_addr  <= w_g1 ? req1_addr : req0_addr;
            sram_wmsk  <= w_g1 ? req1_wmsk : req0_wmsk;
            sram_wdata <= w_g1 ? req1_wdata : req0_wdata;
        end else begin
            sram_cen   <= 1'b1;
            sram_wen   <= 1'b1;
            sram_wmsk  <= '1;
        end
    end
    // Stage 1 marks the command on the pins, stage 2 the edge the macro captured it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_t1_v     <= 1'b0;
            r_t1_id    <= 1'b0;
            r_t2_v     <= 1'b0;
            r_t2_id    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            r_t1_v     <= (w_g0 & !req0_we) | (w_g1 & !req1_we);
            r_t1_id    <= w_g1;
            r_t2_v     <= r_t1_v;
            r_t2_id    <= r_t1_id;
            rsp0_valid <= r_t2_v & !r_t2_id;
            rsp1_valid <= r_t2_v & r_t2_id;
            rsp0_data  <= (r_t2_v & !r_t2_id) ? sram_rdata : rsp0_data;
            rsp1_data  <= (r_t2_v & r_t2_id) ? sram_rdata : rsp1_data;
        end
    end
endmodule
